// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions for the sprite DMA engine: state encoding and fixed
// register addresses.
package nes_bus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
    localparam int          OAM_XFER_LEN = 256;
    localparam int          CYCLE_CNT_W  = 10;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to TRIG_ADDR halts the CPU and copies one page into OAMDATA.
// Optional halted-cycle counter output enabled by `define OAM_DMA_CYCLE_COUNT_EN.
module oam_dma
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] TRIG_ADDR = OAMDMA_ADDR,
    parameter logic [15:0] DEST_ADDR = OAMDATA_ADDR,
    parameter int          XFER_LEN  = OAM_XFER_LEN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            cpu_addr,
    input  logic                   cpu_wr,
    input  logic [7:0]             cpu_data,
    output logic                   cpu_halt,
    output logic [15:0]            dma_addr,
    output logic                   dma_rd,
    input  logic [7:0]             dma_rd_data,
    output logic                   dma_wr,
    output logic [7:0]             dma_wr_data,
`ifdef OAM_DMA_CYCLE_COUNT_EN
    output logic [CYCLE_CNT_W-1:0] dma_cycles,
`endif
    output dma_state_t             dbg_state
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t  state, state_nxt;
    logic        parity;
    logic [7:0]  page;
    logic [7:0]  idx, idx_nxt;
    logic [15:0] addr_q;
    logic        trigger;

    assign trigger   = cpu_wr && (cpu_addr == TRIG_ADDR) && (state == IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            parity <= 1'b0;
            page   <= 8'h00;
            idx    <= 8'h00;
            addr_q <= 16'h0000;
        end else begin
            state  <= state_nxt;
            parity <= ~parity;
            idx    <= idx_nxt;
            addr_q <= dma_addr;
            if (trigger) begin
                page <= cpu_data;
            end
        end
    end

    // dma_addr falls back to addr_q outside READ/WRITE so the bus holds its last address.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cpu_halt    = 1'b1;
        dma_rd      = 1'b0;
        dma_wr      = 1'b0;
        dma_addr    = addr_q;
        dma_wr_data = 8'h00;
        case (state)
            IDLE: begin
                cpu_halt = 1'b0;
                if (trigger) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                // parity=1 now means the following cycle is even, so READ can go straight in.
                state_nxt = parity ? READ : ALIGN;
            end
            ALIGN: begin
                state_nxt = READ;
            end
            READ: begin
                dma_rd    = 1'b1;
                dma_addr  = {page, idx};
                state_nxt = WRITE;
            end
            WRITE: begin
                dma_wr      = 1'b1;
                dma_addr    = DEST_ADDR;
                dma_wr_data = dma_rd_data;
                if (idx == LAST_IDX) begin
                    idx_nxt   = 8'h00;
                    state_nxt = IDLE;
                end else begin
                    idx_nxt   = idx + 8'd1;
                    state_nxt = READ;
                end
            end
            default: begin
                cpu_halt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef OAM_DMA_CYCLE_COUNT_EN
    logic [CYCLE_CNT_W-1:0] cycle_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else if (trigger) begin
            cycle_cnt <= '0;
        end else if (state != IDLE) begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

    assign dma_cycles = cycle_cnt;
`endif

endmodule
